key_matrix_scanner: RTL and testbench
=====================================

Name: key_matrix_scanner

Overview:
- Reads the 8x8 matrix: the input-side counterpart of the column-decoder/row-drive LED matrix path.
- Drives one column low at a time, in the same one-hot active-low pattern as the 138 decoder output. Samples the eight row lines for that column.
- Debounces the full 64-key snapshot. Emits press/release events, one at a time, over a valid/ready handshake to a downstream consumer.

Parameters:
- SETTLE_CYCLES, 4, clocks each column is driven before its rows are sampled; legal range 3..255.
- DEBOUNCE_SCANS, 3, consecutive identical full-scan snapshots required to accept a new key state; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- col_drive_n  output  8  one-hot active-low column drive; bit c low selects column c.
- row_sense_n  input  8  row lines, active low; bit r low = key (driven column, r) closed. Asynchronous to clk.
- key_valid  output  1  event available.
- key_code  output  6  {column[2:0], row[2:0]} of the event key.
- key_pressed  output  1  1 = press event, 0 = release event.
- key_ready  input  1  consumer accepts the event on a clk edge where key_valid=1.
- scan_done  output  1  one-cycle pulse at the end of every full 8-column scan.

Behaviour:
- Reset (async, reset_n=0):
  - col_drive_n=8'hFE, key_valid=0, key_code=0, key_pressed=0, scan_done=0.
  - All internal snapshot, debounced and reported state = all released; stable count = 0.
  - Any pending event is discarded.
- Row input: row_sense_n passes through a 2-flop synchronizer before use.
- Column sequencing:
  - Column index 0..7, wraps 7 to 0.
  - Each column window lasts exactly SETTLE_CYCLES clocks; col_drive_n changes on the first clock of the window.
  - Synchronized rows are captured into snapshot bits [c*8+7 : c*8], pressed=1, on the last clock of the window.
  - Full scan = 8*SETTLE_CYCLES clocks.
  - scan_done pulses on the cycle after the column-7 capture.
  - Scanning never stalls, including during handshake backpressure.
- Debounce, evaluated at each scan end:
  - If the new snapshot equals the previous snapshot, stable_cnt increments, saturating at DEBOUNCE_SCANS; otherwise stable_cnt=1.
  - The previous snapshot is then replaced by the new one.
  - When stable_cnt >= DEBOUNCE_SCANS, the debounced state is set to the new snapshot.
- Event generation:
  - diff = debounced XOR reported.
  - When key_valid=0, or key_valid&&key_ready (same-cycle reload allowed), and diff != 0:
    - Select the lowest set index i.
    - Register key_code=i and key_pressed=debounced[i]; set key_valid=1.
    - Set reported[i]=debounced[i] in the same cycle.
  - If diff=0, key_valid falls after the accept.
  - While key_valid=1 and key_ready=0, key_code and key_pressed are held stable.
  - A key that changes again after its event is loaded produces a further event later; no event is ever merged or dropped.
- Multiple simultaneous changes are reported in ascending index order.
- Ghosting and phantom keys are not resolved; they are reported as seen.

Test Plan (defaults SETTLE_CYCLES=4, DEBOUNCE_SCANS=3):
- Idle after reset, no keys:
  - col_drive_n steps FE,FD,FB,F7,EF,DF,BF,7F, 4 clocks each, then repeats.
  - scan_done pulses every 32 clocks; key_valid stays 0.
- Key (col2,row5) closed and held, key_ready=1:
  - Exactly one event: key_code=21, key_pressed=1, within 4 scans (<=130 clocks).
  - On release, exactly one event: key_code=21, key_pressed=0.
- Key (col4,row0) chattering every 40 clocks for 300 clocks, then open: no event at any time.
- Keys (0,1) and (7,7) pressed together with key_ready=0:
  - key_valid=1 with key_code=1, held unchanged for 200 clocks.
  - After a one-cycle key_ready pulse: key_code=63 next; exactly two events in total.
- Key pressed, then released before the press is accepted: press event (pressed=1) delivered first, then the release event; no loss.
- reset_n pulled low mid-scan with key_valid=1:
  - All outputs take reset values immediately.
  - A key held through reset is reported as a press after reset_n rises.

Source files
------------

// File: rtl/key_matrix_scanner.sv
// rtl/key_matrix_scanner.sv - 8x8 key matrix scanner with full-snapshot debounce and press/release event queue
//
// Purpose:
//   Drives one active-low column at a time, samples the synchronized active-low
//   row lines at the end of each column window, debounces the complete 64-key
//   snapshot over several full scans and hands out press/release events one at
//   a time over a valid/ready handshake.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   reset_n      in   1  asynchronous active-low reset
//   col_drive_n  out  8  one-hot active-low column drive (bit c low = column c)
//   row_sense_n  in   8  row lines, active low, asynchronous to clk
//   key_valid    out  1  event available
//   key_code     out  6  {column[2:0], row[2:0]} of the event key
//   key_pressed  out  1  1 = press, 0 = release
//   key_ready    in   1  consumer accepts the event when key_valid=1
//   scan_done    out  1  one-cycle pulse after every full 8-column scan

module key_matrix_scanner #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] col_drive_n,
    input  logic [7:0] row_sense_n,
    output logic       key_valid,
    output logic [5:0] key_code,
    output logic       key_pressed,
    input  logic       key_ready,
    output logic       scan_done
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DEB_MAX     = 4'(DEBOUNCE_SCANS);

    // ------------------------------------------------------------------
    // Row synchronizer (two flops, rows are asynchronous to clk)
    // ------------------------------------------------------------------
    logic [7:0] r_row_meta;
    logic [7:0] r_row_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row_meta <= 8'hFF;
            r_row_sync <= 8'hFF;
        end else begin
            r_row_meta <= row_sense_n;
            r_row_sync <= r_row_meta;
        end
    end

    // ------------------------------------------------------------------
    // Column sequencer and snapshot capture
    // ------------------------------------------------------------------
    logic [7:0]  r_settle_cnt;
    logic [2:0]  r_col;
    logic [7:0]  r_col_drive_n;
    logic [63:0] r_snap;
    logic        r_scan_done;

    logic        w_capture;
    logic [2:0]  w_col_next;

    assign w_capture  = (r_settle_cnt == SETTLE_LAST);
    assign w_col_next = r_col + 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_settle_cnt  <= 8'd0;
            r_col         <= 3'd0;
            r_col_drive_n <= 8'hFE;
            r_snap        <= 64'd0;
            r_scan_done   <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (w_capture) begin
                // Rows are active low; the snapshot stores pressed=1.
                r_snap[{r_col, 3'b000} +: 8] <= ~r_row_sync;
                r_settle_cnt  <= 8'd0;
                r_col         <= w_col_next;
                // Registered so the new column is driven on the first clock
                // of its window.
                r_col_drive_n <= ~(8'b0000_0001 << w_col_next);
                r_scan_done   <= (r_col == 3'd7);
            end else begin
                r_settle_cnt <= r_settle_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce: evaluated in the scan_done cycle, when the snapshot holds a
    // complete scan. Column 0 of the next scan is captured at least two
    // clocks later, so the snapshot is stable here.
    // ------------------------------------------------------------------
    logic [63:0] r_prev_snap;
    logic [63:0] r_debounced;
    logic [3:0]  r_stable_cnt;
    logic [3:0]  w_stable_next;

    always_comb begin
        w_stable_next = 4'd1;
        if (r_snap == r_prev_snap) begin
            if (r_stable_cnt >= DEB_MAX) begin
                w_stable_next = DEB_MAX;
            end else begin
                w_stable_next = r_stable_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_snap  <= 64'd0;
            r_debounced  <= 64'd0;
            r_stable_cnt <= 4'd0;
        end else if (r_scan_done) begin
            r_stable_cnt <= w_stable_next;
            r_prev_snap  <= r_snap;
            if (w_stable_next >= DEB_MAX) begin
                r_debounced <= r_snap;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event generation: lowest differing index between the debounced state
    // and what the consumer has already been told.
    // ------------------------------------------------------------------
    logic [63:0] r_reported;
    logic        r_key_valid;
    logic [5:0]  r_key_code;
    logic        r_key_pressed;

    logic [63:0] w_diff;
    logic        w_diff_any;
    logic [5:0]  w_evt_idx;
    logic        w_load;

    assign w_diff     = r_debounced ^ r_reported;
    assign w_diff_any = |w_diff;

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        w_evt_idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_evt_idx = 6'(i);
            end
        end
    end

    // A new event may be loaded into an empty slot or into a slot that is
    // being accepted in this same cycle.
    assign w_load = (!r_key_valid || key_ready) && w_diff_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reported    <= 64'd0;
            r_key_valid   <= 1'b0;
            r_key_code    <= 6'd0;
            r_key_pressed <= 1'b0;
        end else if (w_load) begin
            r_key_valid            <= 1'b1;
            r_key_code             <= w_evt_idx;
            r_key_pressed          <= r_debounced[w_evt_idx];
            // Marking the key reported at load time means a later change of
            // the same key reappears in the diff and becomes its own event.
            r_reported[w_evt_idx]  <= r_debounced[w_evt_idx];
        end else if (r_key_valid && key_ready) begin
            r_key_valid <= 1'b0;
        end
    end

    assign col_drive_n = r_col_drive_n;
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_pressed = r_key_pressed;
    assign scan_done   = r_scan_done;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb/tb_key_matrix_scanner.sv - directed self-checking bench for key_matrix_scanner
module tb_key_matrix_scanner;

    logic       clk;
    logic       reset_n;
    logic [7:0] col_drive_n;
    logic [7:0] row_sense_n;
    logic       key_valid;
    logic [5:0] key_code;
    logic       key_pressed;
    logic       key_ready;
    logic       scan_done;

    logic [63:0] keys;

    int n_checks;
    int n_errors;

    logic [5:0] ev_code[$];
    logic       ev_press[$];

    key_matrix_scanner #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .col_drive_n (col_drive_n),
        .row_sense_n (row_sense_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .key_ready   (key_ready),
        .scan_done   (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a closed key pulls its row low while its column is driven.
    always_comb begin
        row_sense_n = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            if (!col_drive_n[c]) begin
                row_sense_n = row_sense_n & ~keys[c*8 +: 8];
            end
        end
    end

    // Accepted-event log
    always @(posedge clk) begin
        if (reset_n && key_valid && key_ready) begin
            ev_code.push_back(key_code);
            ev_press.push_back(key_pressed);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int limit, output int cycles);
        cycles = 0;
        while (!key_valid && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, 32'(key_valid), 32'd1);
    endtask

    task automatic wait_scan_done(input string tag);
        int cycles;
        cycles = 0;
        while (!scan_done && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, 32'(scan_done), 32'd1);
    endtask

    task automatic clear_log();
        ev_code.delete();
        ev_press.delete();
    endtask

    initial begin
        int lat;
        int bad;
        int seen;
        logic [7:0] exp_col;

        n_checks  = 0;
        n_errors  = 0;
        keys      = 64'd0;
        key_ready = 1'b0;
        reset_n   = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_col",     32'(col_drive_n), 32'hFE);
        check("rst_valid",   32'(key_valid),   32'd0);
        check("rst_code",    32'(key_code),    32'd0);
        check("rst_pressed", 32'(key_pressed), 32'd0);
        check("rst_scan",    32'(scan_done),   32'd0);

        // ---------------- idle scanning ----------------
        reset_n = 1'b1;
        for (int k = 0; k < 80; k++) begin
            exp_col = ~(8'd1 << ((k / 4) % 8));
            check("idle_col",   32'(col_drive_n), 32'(exp_col));
            check("idle_scan",  32'(scan_done),   32'((k % 32 == 0) && (k > 0)));
            check("idle_valid", 32'(key_valid),   32'd0);
            @(negedge clk);
        end

        // ---------------- single key press / release ----------------
        key_ready = 1'b1;
        clear_log();
        keys[21] = 1'b1;
        wait_valid("press_timeout", 200, lat);
        check("press_latency_ok", 32'(lat <= 130), 32'd1);
        check("press_code",    32'(key_code),    32'd21);
        check("press_pressed", 32'(key_pressed), 32'd1);
        repeat (150) @(negedge clk);
        check("press_count", 32'(ev_code.size()), 32'd1);
        keys[21] = 1'b0;
        repeat (200) @(negedge clk);
        check("release_count", 32'(ev_code.size()), 32'd2);
        if (ev_code.size() == 2) begin
            check("release_code",    32'(ev_code[1]),  32'd21);
            check("release_pressed", 32'(ev_press[1]), 32'd0);
        end

        // ---------------- chattering key ----------------
        clear_log();
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            keys[32] = ((i / 40) % 2 == 0);
            @(negedge clk);
            if (key_valid) seen++;
        end
        keys[32] = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_valid) seen++;
        end
        check("chatter_valid",  32'(seen),           32'd0);
        check("chatter_events", 32'(ev_code.size()), 32'd0);

        // ---------------- two keys with backpressure ----------------
        key_ready = 1'b0;
        clear_log();
        wait_scan_done("two_align");
        keys[1]  = 1'b1;
        keys[63] = 1'b1;
        wait_valid("two_timeout", 200, lat);
        check("two_first_code",    32'(key_code),    32'd1);
        check("two_first_pressed", 32'(key_pressed), 32'd1);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!key_valid || key_code != 6'd1 || !key_pressed) bad++;
        end
        check("two_hold", 32'(bad), 32'd0);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        check("two_second_valid", 32'(key_valid), 32'd1);
        check("two_second_code",  32'(key_code),  32'd63);
        key_ready = 1'b1;
        repeat (150) @(negedge clk);
        check("two_count", 32'(ev_code.size()), 32'd2);
        if (ev_code.size() == 2) begin
            check("two_order0", 32'(ev_code[0]), 32'd1);
            check("two_order1", 32'(ev_code[1]), 32'd63);
        end
        keys[1]  = 1'b0;
        keys[63] = 1'b0;
        repeat (250) @(negedge clk);

        // ---------------- release before press accepted ----------------
        key_ready = 1'b0;
        clear_log();
        keys[10] = 1'b1;
        wait_valid("quick_timeout", 200, lat);
        check("quick_code",    32'(key_code),    32'd10);
        check("quick_pressed", 32'(key_pressed), 32'd1);
        keys[10] = 1'b0;
        repeat (200) @(negedge clk);
        check("quick_held_pressed", 32'(key_pressed), 32'd1);
        check("quick_held_code",    32'(key_code),    32'd10);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        check("quick_rel_valid",   32'(key_valid),   32'd1);
        check("quick_rel_code",    32'(key_code),    32'd10);
        check("quick_rel_pressed", 32'(key_pressed), 32'd0);
        key_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("quick_count", 32'(ev_code.size()), 32'd2);
        if (ev_code.size() == 2) begin
            check("quick_ev0", 32'(ev_press[0]), 32'd1);
            check("quick_ev1", 32'(ev_press[1]), 32'd0);
        end

        // ---------------- reset mid-scan with pending event ----------------
        key_ready = 1'b0;
        keys[45]  = 1'b1;
        wait_valid("rst2_pre_timeout", 200, lat);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst2_col",     32'(col_drive_n), 32'hFE);
        check("rst2_valid",   32'(key_valid),   32'd0);
        check("rst2_code",    32'(key_code),    32'd0);
        check("rst2_pressed", 32'(key_pressed), 32'd0);
        check("rst2_scan",    32'(scan_done),   32'd0);
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        key_ready = 1'b1;
        wait_valid("rst2_post_timeout", 200, lat);
        check("rst2_post_code",    32'(key_code),    32'd45);
        check("rst2_post_pressed", 32'(key_pressed), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
